vga_alarm_panel: RTL and testbench
==================================

VGA_ALARM_PANEL -- requirements
Module: vga_alarm_panel

Interface
REQ-001 Parameter NUM_CH, default 4: number of sensor channels, 1..8.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive mismatch cycles needed to change a debounced sensor, must be at least 1.
REQ-003 Parameter EXIT_FRAMES, default 3: exit-delay length in frames, 0..255.
REQ-004 Parameter BLINK_FRAMES, default 2: frames per blink half-period, must be at least 1.
REQ-005 Parameter ALWAYS_MASK, default 4'b1100: channels that alarm regardless of arming; other channels alarm only when armed.
REQ-006 Parameter COLORS, default {6'b111111, 6'b111100, 6'b110011, 6'b110011}: packed colour per channel, each {R[1:0],G[1:0],B[1:0]}, channel NUM_CH-1 in the MSBs.
REQ-007 Parameter EXIT_COLOR, default 6'b001100: colour shown during exit delay.
REQ-008 Ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset, in, 1: reset, synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse per frame.
- video_active, in, 1: pixel is inside the visible area.
- arm, in, 1: arming switch, synchronous to clk.
- clear, in, 1: acknowledge pulse, synchronous to clk.
- sensor, in, NUM_CH: raw asynchronous sensor inputs.
- rgb, out, 6: {R[1:0],G[1:0],B[1:0]}, registered.
- state, out, 2: current FSM state.
- latched, out, NUM_CH: latched alarm channels.
- alarm, out, 1: OR of all latched bits.

Function
REQ-009 Each sensor bit SHALL pass through a 2-flop synchroniser (sync) before debouncing.
REQ-010 Debounce, per channel:
- deb[i] SHALL take the value of sync[i] on the DEB_CYCLES-th consecutive edge at which sync[i] differs from deb[i].
- Any agreement between sync[i] and deb[i] SHALL zero that channel's counter.
REQ-011 Sensor-to-latch latency SHALL be DEB_CYCLES+3 edges, which is 7 with defaults; pulses shorter than DEB_CYCLES cycles SHALL be ignored.
REQ-012 State encoding SHALL be DISARMED=0, EXIT=1, ARMED=2, ALARM=3.
REQ-013 arm=0 SHALL force DISARMED on the next edge from any state; this has priority over every other transition.
REQ-014 DISARMED with arm=1 SHALL go to EXIT and load exit_cnt with EXIT_FRAMES.
REQ-015 EXIT countdown:
- On each frame_tick, if exit_cnt<=1 the FSM SHALL go to ARMED; otherwise exit_cnt SHALL decrement.
- With EXIT_FRAMES=0 the FSM SHALL go to ARMED on the edge after entering EXIT.
REQ-016 Latch set vector: set[i] = deb[i] AND (ALWAYS_MASK[i] OR state is ARMED or ALARM).
REQ-017 Latch update: latched SHALL be updated each edge to (latched AND NOT clear-mask) OR set; if set and clear coincide, set wins.
REQ-018 ARMED SHALL go to ALARM on the edge at which latched OR set is non-zero.
REQ-019 ALARM SHALL go to ARMED on the edge after latched becomes all-zero while arm=1.
REQ-020 Latched bits SHALL survive disarming and SHALL only be removed by clear or reset.
REQ-021 Blink:
- blink_phase SHALL toggle after every BLINK_FRAMES frame_ticks.
- The blink counter SHALL be zeroed and blink_phase set to 1 on entry to ALARM or EXIT.
REQ-022 Colour selection, evaluated in order:
- video_active=0 -> black.
- Else if latched is non-zero -> COLORS slice of the highest-index latched bit; in ALARM it is shown only while blink_phase=1 (black otherwise); outside ALARM it is steady.
- Else if state is EXIT -> EXIT_COLOR while blink_phase=1, black otherwise.
- Else black.
REQ-023 rgb SHALL be registered, one edge after video_active and the other inputs are sampled.
REQ-024 frame_tick and clear coinciding with any transition SHALL both take effect on the same edge.

Reset
REQ-025 reset=1 SHALL, on the next edge and overriding all inputs, set:
- state=DISARMED;
- rgb, latched and alarm to 0;
- sync, deb, debounce counters, exit_cnt and blink counter to 0;
- blink_phase=1.
REQ-026 Asserting reset mid-alarm or mid-exit SHALL abort the operation with no residual latched bit.

Verification
REQ-027 Glitch rejection: sensor[0] high for 3 cycles with state ARMED -> latched stays 0 and state stays ARMED.
REQ-028 Armed intrusion:
- Stimulus: arm=1, 3 frame_ticks, then sensor[0] held high.
- Response: state 1 then 2; 7 edges after the sensor rises, latched=4'b0001 and state=3.
- With video_active=1, rgb=6'b110011 during blink-on and 0 during blink-off, toggling every 2 frame_ticks.
REQ-029 Always-on while disarmed: arm=0, sensor[3] high -> latched=4'b1000, state=0, steady rgb=6'b111111 while video_active=1.
REQ-030 Priority and clear:
- Stimulus: sensor[2] and sensor[3] latched, then sensor[3] released and clear pulsed while sensor[2] is still high.
- Response: rgb white before the clear; latched=4'b0100 and rgb=6'b111100 after the clear.
REQ-031 Exit abort: arm=1, then arm=0 after 1 frame_tick -> state=0; sensor[0] asserted during EXIT never latches.
REQ-032 Reset mid-alarm: reset asserted for 1 cycle while in ALARM -> next edge shows state=0, latched=0, alarm=0, rgb=0.

Source files
------------

// File: rtl/vga_alarm_panel.sv
// Alarm panel: synchronised, debounced sensor channels feed an arm/exit/alarm FSM
// whose latched alarms are rendered as a blinking or steady colour on the video stream.
module vga_alarm_panel #(
  parameter int unsigned           NUM_CH       = 4,
  parameter int unsigned           DEB_CYCLES   = 4,
  parameter int unsigned           EXIT_FRAMES  = 3,
  parameter int unsigned           BLINK_FRAMES = 2,
  parameter logic [NUM_CH-1:0]     ALWAYS_MASK  = 4'b1100,
  parameter logic [6*NUM_CH-1:0]   COLORS       = {6'b111111, 6'b111100, 6'b110011, 6'b110011},
  parameter logic [5:0]            EXIT_COLOR   = 6'b001100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              video_active,
  input  logic              arm,
  input  logic              clear,
  input  logic [NUM_CH-1:0] sensor,
  output logic [5:0]        rgb,
  output logic [1:0]        state,
  output logic [NUM_CH-1:0] latched,
  output logic              alarm
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StExit     = 2'd1,
    StArmed    = 2'd2,
    StAlarm    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] sync1_q, sync_q;
  logic [NUM_CH-1:0] deb_q, deb_d;
  logic [CW-1:0]     deb_cnt_q [NUM_CH];
  logic [CW-1:0]     deb_cnt_d [NUM_CH];
  logic [7:0]        exit_q, exit_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [NUM_CH-1:0] latched_q, latched_d, set_vec;
  logic [5:0]        rgb_q, rgb_d, ch_color;
  logic              entering;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign set_vec   = deb_q & (ALWAYS_MASK |
                     {NUM_CH{(state_q == StArmed) || (state_q == StAlarm)}});
  // Set dominates clear so an active sensor cannot be acknowledged away.
  assign latched_d = (latched_q & ~{NUM_CH{clear}}) | set_vec;

  always_comb begin
    state_d = state_q;
    exit_d  = exit_q;
    if (!arm) begin
      state_d = StDisarmed;
    end else begin
      unique case (state_q)
        StDisarmed: begin
          state_d = StExit;
          exit_d  = 8'(EXIT_FRAMES);
        end
        StExit: begin
          if (exit_q == 8'd0) begin
            state_d = StArmed;
          end else if (frame_tick) begin
            if (exit_q <= 8'd1) state_d = StArmed;
            else                exit_d  = exit_q - 8'd1;
          end
        end
        StArmed: if ((latched_q | set_vec) != '0) state_d = StAlarm;
        StAlarm: if (latched_q == '0) state_d = StArmed;
        default: state_d = StDisarmed;
      endcase
    end
  end

  assign entering = (state_d != state_q) && ((state_d == StAlarm) || (state_d == StExit));

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (entering) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Ascending scan leaves the highest-index latched channel's colour.
  always_comb begin
    ch_color = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (latched_q[i]) ch_color = COLORS[6*i +: 6];
    end
  end

  always_comb begin
    rgb_d = '0;
    if (video_active) begin
      if (latched_q != '0) begin
        if ((state_q != StAlarm) || phase_q) rgb_d = ch_color;
      end else if ((state_q == StExit) && phase_q) begin
        rgb_d = EXIT_COLOR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StDisarmed;
      sync1_q     <= '0;
      sync_q      <= '0;
      deb_q       <= '0;
      exit_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      latched_q   <= '0;
      rgb_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) deb_cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sensor;
      sync_q      <= sync1_q;
      deb_q       <= deb_d;
      exit_q      <= exit_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      latched_q   <= latched_d;
      rgb_q       <= rgb_d;
      for (int i = 0; i < NUM_CH; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign rgb     = rgb_q;
  assign state   = state_q;
  assign latched = latched_q;
  assign alarm   = |latched_q;

endmodule

// File: tb/tb_vga_alarm_panel.sv
// Directed bench for vga_alarm_panel with default parameters; expected values hand-computed.
module tb_vga_alarm_panel;

  logic       clk = 1'b0;
  logic       reset, frame_tick, video_active, arm, clear;
  logic [3:0] sensor;
  logic [5:0] rgb;
  logic [1:0] state;
  logic [3:0] latched;
  logic       alarm;

  int errors = 0;
  int checks = 0;

  vga_alarm_panel dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .video_active (video_active),
    .arm          (arm),
    .clear        (clear),
    .sensor       (sensor),
    .rgb          (rgb),
    .state        (state),
    .latched      (latched),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; video_active = 1'b1;
    arm = 1'b0; clear = 1'b0; sensor = 4'b0000;
    step();
    step();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_latched", 32'(latched), 32'd0);
    chk("reset_alarm", 32'(alarm), 32'd0);
    chk("reset_rgb", 32'(rgb), 32'd0);
    reset = 1'b0;

    // Arm, run through exit delay.
    arm = 1'b1;
    step();
    chk("enter_exit", 32'(state), 32'd1);
    step();
    chk("exit_color_on", 32'(rgb), 32'h0c);
    tick(); tick();
    chk("exit_color_off", 32'(rgb), 32'd0);
    chk("still_exit", 32'(state), 32'd1);
    tick();
    chk("armed", 32'(state), 32'd2);

    // Glitch rejection.
    sensor = 4'b0001;
    repeat (3) step();
    sensor = 4'b0000;
    repeat (8) step();
    chk("glitch_latched", 32'(latched), 32'd0);
    chk("glitch_state", 32'(state), 32'd2);

    // Armed intrusion, 7-edge latency.
    sensor = 4'b0001;
    repeat (6) step();
    chk("intr_pre_latched", 32'(latched), 32'd0);
    chk("intr_pre_state", 32'(state), 32'd2);
    step();
    chk("intr_latched", 32'(latched), 32'd1);
    chk("intr_state", 32'(state), 32'd3);
    step();
    chk("intr_rgb_on", 32'(rgb), 32'h33);
    chk("intr_alarm", 32'(alarm), 32'd1);
    tick(); tick();
    chk("intr_rgb_off", 32'(rgb), 32'd0);
    tick(); tick();
    chk("intr_rgb_on2", 32'(rgb), 32'h33);

    // Disarm keeps the latch; clear removes it once the sensor is quiet.
    sensor = 4'b0000; arm = 1'b0;
    step();
    chk("disarm_state", 32'(state), 32'd0);
    chk("disarm_keeps_latch", 32'(latched), 32'd1);
    repeat (8) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_latched", 32'(latched), 32'd0);
    chk("clear_alarm", 32'(alarm), 32'd0);

    // Exit abort; sensor[0] during exit never latches.
    arm = 1'b1;
    step();
    chk("abort_exit", 32'(state), 32'd1);
    sensor = 4'b0001;
    tick();
    arm = 1'b0;
    step();
    chk("abort_state", 32'(state), 32'd0);
    repeat (8) step();
    chk("abort_latched", 32'(latched), 32'd0);
    sensor = 4'b0000;
    repeat (8) step();

    // Always-on channel while disarmed.
    sensor = 4'b1000;
    repeat (7) step();
    chk("always_latched", 32'(latched), 32'h8);
    chk("always_state", 32'(state), 32'd0);
    step();
    chk("always_rgb", 32'(rgb), 32'h3f);
    tick(); tick();
    chk("always_rgb_steady", 32'(rgb), 32'h3f);
    video_active = 1'b0;
    step();
    chk("blank_rgb", 32'(rgb), 32'd0);
    video_active = 1'b1;

    // Priority and clear with set winning.
    sensor = 4'b1100;
    repeat (7) step();
    chk("prio_latched", 32'(latched), 32'hc);
    step();
    chk("prio_rgb_white", 32'(rgb), 32'h3f);
    sensor = 4'b0100;
    repeat (8) step();
    chk("prio_hold", 32'(latched), 32'hc);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("prio_after_clear", 32'(latched), 32'h4);
    step();
    chk("prio_rgb_yellow", 32'(rgb), 32'h3c);

    // Arm with a latched bit: steady in exit, then straight into alarm.
    arm = 1'b1;
    step();
    chk("relatch_exit", 32'(state), 32'd1);
    step();
    chk("exit_steady_rgb", 32'(rgb), 32'h3c);
    tick(); tick();
    chk("exit_steady_rgb2", 32'(rgb), 32'h3c);
    tick();
    chk("to_alarm", 32'(state), 32'd3);
    step();
    chk("alarm_rgb_on", 32'(rgb), 32'h3c);

    // Reset mid-alarm.
    reset = 1'b1;
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_latched", 32'(latched), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    reset = 1'b0; sensor = 4'b0000;
    step();
    chk("post_rst_exit", 32'(state), 32'd1);
    repeat (8) step();
    chk("post_rst_latched", 32'(latched), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
